// File: rtl/pcie4_cfg_msix_irq_sched_pkg.sv
// Shared types and constants for the PCIe4 MSI-X interrupt scheduler.
package pcie4_msix_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        BACKOFF = 2'd3
    } state_t;

    localparam int MSIX_DATA_W = 32;
    localparam int MSIX_ADDR_W = 64;

    // Bits needed to index 'value' distinct items (0 for value <= 1).
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/pcie4_cfg_msix_irq_sched_rr_arbiter.sv
// Combinational round-robin picker: first asserted request after ptr, wrapping.
module rr_arbiter
    import pcie4_msix_sched_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int cand;

    // Walk from the farthest offset to the nearest so the nearest hit wins last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int off = N; off >= 1; off--) begin
            cand = int'(ptr) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req[cand[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pcie4_cfg_msix_irq_sched.sv
// MSI-X interrupt scheduler: latches source edges as pending and issues them
// one at a time on the PCIe4 cfg MSI-X port, retrying after fail or timeout.
module pcie4_cfg_msix_irq_sched
    import pcie4_msix_sched_pkg::*;
#(
    parameter int N_SRC     = 8,
    parameter int FUNC_NUM  = 0,
    parameter int TIMEOUT   = 1023,
    parameter int RETRY_GAP = 15,
    parameter int ERR_CNT_W = 16
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [N_SRC-1:0]       irq_req,
    output logic [N_SRC-1:0]       irq_ack,
    input  logic [3:0]             m_enable,
    input  logic [3:0]             m_mask,
    output logic [MSIX_DATA_W-1:0] m_data,
    output logic [MSIX_ADDR_W-1:0] m_address,
    output logic                   m_int_vector,
    input  logic                   m_sent,
    input  logic                   m_fail,
    output logic [7:0]             m_function_number,
    output logic [1:0]             m_vec_pending,
    output logic [2:0]             m_attr,
    output logic                   m_tph_present,
    output logic [1:0]             m_tph_type,
    output logic [7:0]             m_tph_st_tag,
    output logic                   busy,
    output logic [ERR_CNT_W-1:0]   err_count
);

    localparam int         IDX_W   = (N_SRC > 1) ? clog2(N_SRC) : 1;
    localparam int         CNT_MAX = (TIMEOUT > RETRY_GAP) ? TIMEOUT : RETRY_GAP;
    localparam int         CNT_W   = clog2(CNT_MAX + 1);
    localparam logic [1:0] FSEL    = FUNC_NUM[1:0];

    state_t             state;
    state_t             state_nxt;
    logic [N_SRC-1:0]   req_q;
    logic [N_SRC-1:0]   req_qq;
    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   pending;
    logic [N_SRC-1:0]   grant_hot;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;
    logic               gate;
    logic               arb_valid;
    logic [IDX_W-1:0]   arb_idx;
    logic               timed_out;
    logic               sent_ok;
    logic               wait_err;
    logic               unused_ok;

    rr_arbiter #(.N(N_SRC), .IDX_W(IDX_W)) u_arb (
        .req   (pending),
        .ptr   (ptr),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    assign rise      = req_q & ~req_qq;
    assign gate      = m_enable[FSEL] & ~m_mask[FSEL];
    assign grant_hot = N_SRC'(1) << grant;
    assign timed_out = (cnt == CNT_W'(TIMEOUT));
    // Sent wins over a simultaneous fail.
    assign sent_ok   = (state == WAIT) && m_sent;
    assign wait_err  = (state == WAIT) && !m_sent && (m_fail || timed_out);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gate && arb_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (sent_ok) state_nxt = IDLE;
                     else if (wait_err) state_nxt = BACKOFF;
            BACKOFF: if (cnt == CNT_W'(RETRY_GAP)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            req_q     <= '0;
            req_qq    <= '0;
            pending   <= '0;
            grant     <= '0;
            ptr       <= '0;
            cnt       <= '0;
            irq_ack   <= '0;
            err_count <= '0;
        end else begin
            state   <= state_nxt;
            req_q   <= irq_req;
            req_qq  <= req_q;
            irq_ack <= sent_ok ? grant_hot : '0;
            // A fresh edge wins over a same-cycle clear so it is never dropped.
            pending <= (pending & ~(sent_ok ? grant_hot : '0)) | rise;
            if (state == IDLE && state_nxt == ISSUE) begin
                grant <= arb_idx;
            end
            if (sent_ok) begin
                ptr <= grant;
            end
            if (wait_err && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
            case (state)
                ISSUE:   cnt <= CNT_W'(1);
                WAIT:    cnt <= wait_err ? CNT_W'(1) : cnt + 1'b1;
                BACKOFF: cnt <= cnt + 1'b1;
                default: cnt <= '0;
            endcase
        end
    end

    assign m_int_vector      = (state == ISSUE);
    assign busy              = (state != IDLE);
    assign m_data            = MSIX_DATA_W'(grant);
    assign m_address         = '0;
    assign m_function_number = 8'(FUNC_NUM);
    assign m_vec_pending     = '0;
    assign m_attr            = '0;
    assign m_tph_present     = 1'b0;
    assign m_tph_type        = '0;
    assign m_tph_st_tag      = '0;
    assign unused_ok         = ^{m_enable, m_mask};

endmodule
